// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_mux
// Summary  : Time-multiplexed seven-segment scanner with refresh prescaler,
//            anti-ghosting guard interval, per-digit blanking and frame pulse.
// Revision : 1.0
// ============================================================================
module seg_scan_mux #(
    parameter int NUM_DIGITS       = 4,
    parameter int SEG_W            = 7,
    parameter int REFRESH_DIV      = 100000,
    parameter int BLANK_CYCLES     = 0,
    parameter bit ANODE_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW   = 1'b1,
    localparam int c_idx_w = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
    input  logic [NUM_DIGITS-1:0]       blank,
    output logic [SEG_W-1:0]            seg_out,
    output logic [NUM_DIGITS-1:0]       an_out,
    output logic [c_idx_w-1:0]          digit_idx,
    output logic                        frame_tick
);

    localparam int c_cnt_w = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [c_cnt_w-1:0]    c_cnt_last = c_cnt_w'(REFRESH_DIV - 1);
    localparam logic [c_idx_w-1:0]    c_idx_last = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_an_off   = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
    localparam logic [SEG_W-1:0]      c_seg_off  = {SEG_W{SEG_ACTIVE_LOW}};

    // Elaboration-time parameter legality
    generate
        if (NUM_DIGITS < 2) begin : g_chk_digits
            $error("seg_scan_mux: NUM_DIGITS must be at least 2");
        end
        if (REFRESH_DIV < 2) begin : g_chk_div
            $error("seg_scan_mux: REFRESH_DIV must be at least 2");
        end
        if (BLANK_CYCLES >= REFRESH_DIV) begin : g_chk_blank
            $error("seg_scan_mux: BLANK_CYCLES must be less than REFRESH_DIV");
        end
    endgenerate

    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_idx_w-1:0]    r_idx;

    logic                  w_slot_end;
    logic                  w_last_digit;
    logic                  w_past_guard;
    logic                  w_blank_sel;
    logic                  w_lit;
    logic [SEG_W-1:0]      w_seg_sel;
    logic [NUM_DIGITS-1:0] w_an_next;

    assign w_slot_end   = (r_cnt == c_cnt_last);
    assign w_last_digit = (r_idx == c_idx_last);
    assign digit_idx    = r_idx;

    // A zero-length guard needs no comparator; avoids a constant-true compare.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_guard
            assign w_past_guard = 1'b1;
        end else begin : g_guard
            assign w_past_guard = (r_cnt >= c_cnt_w'(BLANK_CYCLES));
        end
    endgenerate

    always_comb begin
        w_seg_sel   = c_seg_off;
        w_blank_sel = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == c_idx_w'(i)) begin
                w_seg_sel   = seg_in[i*SEG_W +: SEG_W];
                w_blank_sel = blank[i];
            end
        end
    end

    assign w_lit = en && w_past_guard && !w_blank_sel;

    always_comb begin
        w_an_next = c_an_off;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_lit && (r_idx == c_idx_w'(i))) begin
                w_an_next[i] = ~ANODE_ACTIVE_LOW;
            end
        end
    end

    // Outputs are computed from pre-edge cnt/idx, so they trail digit_idx by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            frame_tick <= 1'b0;
            an_out     <= c_an_off;
            seg_out    <= c_seg_off;
        end else begin
            an_out     <= w_an_next;
            seg_out    <= en ? w_seg_sel : c_seg_off;
            frame_tick <= en && w_slot_end && w_last_digit;
            if (en) begin
                if (w_slot_end) begin
                    r_cnt <= '0;
                    r_idx <= w_last_digit ? '0 : r_idx + 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
